// File: rtl/hamming_decoder.sv
// SEC-DED Hamming(16,11) decoder with valid/ready handshake.
// Fixed 3-edge latency, held result, and saturating error counters.
module hamming_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [7:0]       MSW,
  input  logic [7:0]       LSW,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       regA,
  output logic [7:0]       regB,
  output logic [1:0]       status,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] sec_cnt,
  output logic [CNT_W-1:0] ded_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [15:0] code;
  logic [3:0]  syn;
  logic        par;
  logic [3:0]  syn_c;
  logic [15:0] fixed;
  logic [1:0]  stat_c;
  logic        handoff;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: state_d = FIX;
      FIX:  state_d = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign handoff = (state_q == HOLD) && out_ready;

  always_comb begin
    syn_c = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (code[k]) syn_c = syn_c ^ 4'(k);
    end
  end

  // p0-only errors leave the data untouched but still count as corrected
  always_comb begin
    fixed  = code;
    stat_c = 2'b00;
    unique case ({syn != 4'd0, par})
      2'b00: stat_c = 2'b00;
      2'b01: stat_c = 2'b01;
      2'b11: begin
        fixed[syn] = ~code[syn];
        stat_c     = 2'b01;
      end
      2'b10: stat_c = 2'b10;
      default: stat_c = 2'b00;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      code   <= '0;
      syn    <= '0;
      par    <= 1'b0;
      regA   <= '0;
      regB   <= '0;
      status <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) code <= {MSW, LSW};
        CALC: begin
          syn <= syn_c;
          par <= ^code;
        end
        FIX: begin
          regA   <= {5'b0, fixed[15:13]};
          regB   <= {fixed[12:9], fixed[7:5], fixed[3]};
          status <= stat_c;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (cnt_clear) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (handoff) begin
      if (status == 2'b01 && sec_cnt != CNT_MAX) sec_cnt <= sec_cnt + 1'b1;
      if (status == 2'b10 && ded_cnt != CNT_MAX) ded_cnt <= ded_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: directed vectors plus
// random encoded words with injected single/double errors.
module tb_hamming_decoder;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 0;
  logic          Reset = 1;
  logic [7:0]    MSW = 0;
  logic [7:0]    LSW = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [7:0]    regA;
  logic [7:0]    regB;
  logic [1:0]    status;
  logic          out_valid;
  logic          out_ready = 0;
  logic          cnt_clear = 0;
  logic [CW-1:0] sec_cnt;
  logic [CW-1:0] ded_cnt;

  hamming_decoder #(.CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .MSW(MSW), .LSW(LSW),
    .in_valid(in_valid), .in_ready(in_ready),
    .regA(regA), .regB(regB), .status(status),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt_clear(cnt_clear), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total = 0;
  int   m_sec = 0;
  int   m_ded = 0;
  int   rdy_mode = 1;
  logic held = 0;
  exp_t held_v;
  int   dpos[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
  endtask

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < 11; i++) c[dpos[i]] = d[i];
    for (int p = 1; p < 16; p = p * 2) begin
      logic x;
      x = 1'b0;
      for (int k = 1; k < 16; k++)
        if (k != p && (k & p) != 0) x = x ^ c[k];
      c[p] = x;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [15:0] extract(input logic [15:0] c);
    logic [10:0] d;
    for (int i = 0; i < 11; i++) d[i] = c[dpos[i]];
    return {5'b0, d[10:8], d[7:0]};
  endfunction

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge CLK) begin
    if (!Reset) begin
      exp_t e;
      logic hs;
      e  = '0;
      hs = 1'b0;
      chk("sec_cnt", int'(sec_cnt), m_sec);
      chk("ded_cnt", int'(ded_cnt), m_ded);
      if (out_valid) begin
        chk("in_ready_busy", int'(in_ready), 0);
        if (held) begin
          chk("hold_regA", int'(regA), int'(held_v.a));
          chk("hold_regB", int'(regB), int'(held_v.b));
          chk("hold_status", int'(status), int'(held_v.st));
        end
        held   = 1;
        held_v = {regA, regB, status};
        if (out_ready) begin
          held = 0;
          if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e  = q.pop_front();
            hs = 1'b1;
            chk("regA", int'(regA), int'(e.a));
            chk("regB", int'(regB), int'(e.b));
            chk("status", int'(status), int'(e.st));
          end
        end
      end else begin
        held = 0;
      end
      if (cnt_clear) begin
        m_sec = 0;
        m_ded = 0;
      end else if (hs) begin
        if (e.st == 2'b01 && m_sec < CMAX) m_sec++;
        if (e.st == 2'b10 && m_ded < CMAX) m_ded++;
      end
    end
  end

  always @(posedge CLK) begin
    #2;
    if (rdy_mode == 0) begin
      out_ready = ($urandom_range(0, 2) != 0);
      cnt_clear = ($urandom_range(0, 199) == 0);
    end else if (rdy_mode == 1) begin
      out_ready = 1'b1;
    end else begin
      out_ready = 1'b0;
    end
  end

  task automatic send(input logic [7:0] m, input logic [7:0] l, input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    MSW = m;
    LSW = l;
    in_valid = 1;
    q.push_back(e);
    @(posedge CLK); #1;
    in_valid = 0;
    MSW = 8'($urandom);
    LSW = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    if (q.size() != 0 || !in_ready) chk("drain_timeout", 0, 1);
  endtask

  task automatic rand_word(input int kind);
    logic [15:0] c;
    logic [15:0] x;
    int p1;
    int p2;
    exp_t e;
    c = encode(11'($urandom));
    x = extract(c);
    e = {x, 2'b00};
    if (kind == 1) begin
      c[$urandom_range(0, 15)] ^= 1'b1;
      e.st = 2'b01;
    end else if (kind == 2) begin
      p1 = $urandom_range(0, 15);
      p2 = (p1 + $urandom_range(1, 15)) % 16;
      c[p1] ^= 1'b1;
      c[p2] ^= 1'b1;
      x = extract(c);
      e = {x, 2'b10};
    end
    send(c[15:8], c[7:0], e);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_regA", int'(regA), 0);
    chk("rst_regB", int'(regB), 0);
    chk("rst_status", int'(status), 0);
    chk("rst_sec", int'(sec_cnt), 0);
    chk("rst_ded", int'(ded_cnt), 0);
    Reset = 0;
    @(posedge CLK); #1;

    send(8'h00, 8'h0F, '{8'h00, 8'h01, 2'b00});
    chk("lat_edge1", int'(out_valid), 0);
    @(posedge CLK); #1;
    chk("lat_edge2", int'(out_valid), 0);
    @(posedge CLK); #1;
    chk("lat_edge3", int'(out_valid), 1);
    wait_idle();

    send(8'h00, 8'h2F, '{8'h00, 8'h01, 2'b01});
    wait_idle();
    chk("sec_after_2F", int'(sec_cnt), 1);
    send(8'h00, 8'h0E, '{8'h00, 8'h01, 2'b01});
    send(8'hFF, 8'hFF, '{8'h07, 8'hFF, 2'b00});
    send(8'h00, 8'h6F, '{8'h00, 8'h07, 2'b10});
    wait_idle();
    chk("ded_after_6F", int'(ded_cnt), 1);
    chk("sec_after_6F", int'(sec_cnt), 2);

    rdy_mode = 2;
    out_ready = 0;
    send(8'h00, 8'h2F, '{8'h00, 8'h01, 2'b01});
    for (int n = 0; n < 20 && !out_valid; n++) begin
      @(posedge CLK); #1;
    end
    chk("stall_valid", int'(out_valid), 1);
    repeat (5) begin
      @(posedge CLK); #1;
    end
    cnt_clear = 1;
    rdy_mode = 1;
    out_ready = 1;
    @(posedge CLK); #1;
    cnt_clear = 0;
    chk("clr_sec", int'(sec_cnt), 0);
    chk("clr_ded", int'(ded_cnt), 0);

    send(8'h00, 8'h2F, '{8'h00, 8'h01, 2'b01});
    @(posedge CLK); #1;
    Reset = 1;
    q.delete();
    m_sec = 0;
    m_ded = 0;
    held = 0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_regA", int'(regA), 0);
    chk("mid_rst_regB", int'(regB), 0);
    chk("mid_rst_status", int'(status), 0);
    @(posedge CLK); #1;
    Reset = 0;
    @(posedge CLK); #1;
    chk("post_rst_ready", int'(in_ready), 1);
    send(8'h00, 8'h0F, '{8'h00, 8'h01, 2'b00});
    wait_idle();
    chk("post_rst_sec", int'(sec_cnt), 0);

    for (int i = 0; i < 20; i++) rand_word(2);
    wait_idle();
    chk("ded_saturate", int'(ded_cnt), CMAX);

    rdy_mode = 0;
    for (int i = 0; i < 300; i++) rand_word($urandom_range(0, 2));
    rdy_mode = 1;
    @(posedge CLK); #1;
    cnt_clear = 0;
    wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
